// File: rtl/tseq_pkg.sv
// Shared state encoding and default widths for the T flip-flop pulse sequencer.
package tseq_pkg;

    localparam int TSEQ_CNT_W = 8;
    localparam int TSEQ_GAP_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } tseq_state_e;

endpackage

// File: rtl/tseq_down_counter.sv
// Saturating down counter with clear > load > decrement priority and an is-one flag.
// Stops at zero rather than wrapping.
module tseq_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    input  logic         i_clr,
    output logic [W-1:0] o_val,
    output logic         o_is_one
);

    logic [W-1:0] r_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_val <= '0;
        end else if (i_clr) begin
            r_val <= '0;
        end else if (i_load) begin
            r_val <= i_load_val;
        end else if (i_dec && (r_val != '0)) begin
            r_val <= r_val - 1'b1;
        end
    end

    assign o_val    = r_val;
    assign o_is_one = (r_val == W'(1));

endmodule

// File: rtl/t_pulse_sequencer.sv
// Turns one start request into N one-cycle t pulses spaced by G idle cycles; first t one cycle after acceptance.
// No backpressure: start is taken only while ready, otherwise dropped. t/done are registered outputs.
// TSEQ_QMIRROR_EN adds q_mirror, an internal copy of the downstream TFF state.
module t_pulse_sequencer
    import tseq_pkg::*;
#(
    parameter int CNT_W = TSEQ_CNT_W,
    parameter int GAP_W = TSEQ_GAP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] pulse_cnt,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             t,
    output logic             done,
    output logic [CNT_W-1:0] pulses_left
`ifdef TSEQ_QMIRROR_EN
    ,
    output logic             q_mirror
`endif
);

    tseq_state_e      r_state;
    tseq_state_e      w_next;
    logic [GAP_W-1:0] r_gap;
    logic             r_t;
    logic             r_done;

    logic             w_accept;
    logic             w_cnt_dec;
    logic             w_clr;
    logic             w_gap_load;
    logic             w_gap_dec;
    logic             w_cnt_one;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_gap_one;
    logic [GAP_W-1:0] w_gap_val;

    tseq_down_counter #(.W(CNT_W)) u_pulse_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (pulse_cnt),
        .i_dec      (w_cnt_dec),
        .i_clr      (w_clr),
        .o_val      (w_cnt_val),
        .o_is_one   (w_cnt_one)
    );

    tseq_down_counter #(.W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_gap_load),
        .i_load_val (r_gap),
        .i_dec      (w_gap_dec),
        .i_clr      (w_clr),
        .o_val      (w_gap_val),
        .o_is_one   (w_gap_one)
    );

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_cnt_dec  = 1'b0;
        w_clr      = 1'b0;
        w_gap_load = 1'b0;
        w_gap_dec  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_accept = 1'b1;
                    w_next   = (pulse_cnt == '0) ? S_DONE : S_PULSE;
                end
            end
            S_PULSE: begin
                if (abort) begin
                    w_clr  = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                    if (w_cnt_one) begin
                        w_next = S_DONE;
                    end else if (r_gap != '0) begin
                        w_gap_load = 1'b1;
                        w_next     = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_clr  = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_gap_dec = 1'b1;
                    // A zero count here is unreachable; treat it like one so GAP can never stall.
                    if (w_gap_one || (w_gap_val == '0)) begin
                        w_next = S_PULSE;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_gap   <= '0;
            r_t     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_t     <= (w_next == S_PULSE);
            r_done  <= (w_next == S_DONE);
            if (w_accept) begin
                r_gap <= gap;
            end
        end
    end

    assign t           = r_t;
    assign done        = r_done;
    assign ready       = (r_state == S_IDLE);
    assign busy        = (r_state == S_PULSE) || (r_state == S_GAP);
    assign pulses_left = w_cnt_val;

`ifdef TSEQ_QMIRROR_EN
    logic r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= 1'b0;
        end else if (r_t) begin
            r_q <= ~r_q;
        end
    end

    assign q_mirror = r_q;
`endif

endmodule

// File: tb/tb_t_pulse_sequencer.sv
// Bench for t_pulse_sequencer: table of bursts plus hand sequences for abort, ignored start and mid-burst reset.
module tb_t_pulse_sequencer;

    typedef struct packed {
        logic       t;
        logic       done;
        logic       ready;
        logic       busy;
        logic [7:0] left;
    } obs_t;

    typedef struct {
        int cnt;
        int gap;
        int exp_pulses;
        int exp_busy;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] pulse_cnt;
    logic [7:0] gap;
    logic       abort;
    logic       ready;
    logic       busy;
    logic       t;
    logic       done;
    logic [7:0] pulses_left;
`ifdef TSEQ_QMIRROR_EN
    logic       q_mirror;
`endif

    int   n_cmp;
    int   n_bad;
    logic m_q;
    obs_t q_exp[$];
    vec_t vecs[6];

    t_pulse_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pulse_cnt   (pulse_cnt),
        .gap         (gap),
        .abort       (abort),
        .ready       (ready),
        .busy        (busy),
        .t           (t),
        .done        (done),
        .pulses_left (pulses_left)
`ifdef TSEQ_QMIRROR_EN
        ,
        .q_mirror    (q_mirror)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic tt, input logic dd, input logic rr, input logic bb, input int l);
        obs_t o;
        o.t     = tt;
        o.done  = dd;
        o.ready = rr;
        o.busy  = bb;
        o.left  = 8'(l);
        return o;
    endfunction

    task automatic check_obs(input string nm, input obs_t exp);
        obs_t act;
        act = {t, done, ready, busy, pulses_left};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got t=%b done=%b ready=%b busy=%b left=%0d, want t=%b done=%b ready=%b busy=%b left=%0d",
                     nm, act.t, act.done, act.ready, act.busy, act.left,
                     exp.t, exp.done, exp.ready, exp.busy, exp.left);
        end
`ifdef TSEQ_QMIRROR_EN
        n_cmp++;
        if (q_mirror !== m_q) begin
            n_bad++;
            $display("FAIL %s_q: got q_mirror=%b, want %b", nm, q_mirror, m_q);
        end
`endif
        if (exp.t) m_q = ~m_q;
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic push_burst(input int n, input int g);
        for (int i = 0; i < n; i++) begin
            q_exp.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, n - i));
            if (i < n - 1) begin
                for (int j = 0; j < g; j++) q_exp.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, n - 1 - i));
            end
        end
        q_exp.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0));
        q_exp.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0));
    endtask

    // Called at a falling edge; the next rising edge accepts the request.
    task automatic start_burst(input int n, input int g);
        start     = 1'b1;
        abort     = 1'b0;
        pulse_cnt = 8'(n);
        gap       = 8'(g);
        push_burst(n, g);
        @(negedge clk);
        start     = 1'b0;
        pulse_cnt = 8'($urandom);
        gap       = 8'($urandom);
    endtask

    task automatic run_q(input string nm, input int abort_idx, input int bstart_idx,
                         output int n_t, output int n_busy);
        obs_t e;
        int   i;
        i      = 0;
        n_t    = 0;
        n_busy = 0;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            if (t === 1'b1) n_t++;
            if (busy === 1'b1) n_busy++;
            check_obs(nm, e);
            abort = (i == abort_idx);
            start = (i == bstart_idx);
            if (i == bstart_idx) pulse_cnt = 8'd9;
            i++;
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        obs_t idle;
        int   nt;
        int   nb;

        vecs[0] = '{cnt: 3, gap: 2, exp_pulses: 3, exp_busy: 7};
        vecs[1] = '{cnt: 4, gap: 0, exp_pulses: 4, exp_busy: 4};
        vecs[2] = '{cnt: 0, gap: 0, exp_pulses: 0, exp_busy: 0};
        vecs[3] = '{cnt: 1, gap: 5, exp_pulses: 1, exp_busy: 1};
        vecs[4] = '{cnt: 2, gap: 3, exp_pulses: 2, exp_busy: 5};
        vecs[5] = '{cnt: 6, gap: 1, exp_pulses: 6, exp_busy: 11};

        n_cmp     = 0;
        n_bad     = 0;
        m_q       = 1'b0;
        idle      = mk(1'b0, 1'b0, 1'b1, 1'b0, 0);
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        pulse_cnt = 8'd0;
        gap       = 8'd0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_obs("reset_hold", idle);
        end
        reset = 1'b1;
        @(negedge clk);
        check_obs("reset_release", idle);
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            start_burst(vecs[v].cnt, vecs[v].gap);
            run_q($sformatf("burst%0d", v), -1, -1, nt, nb);
            check_int($sformatf("burst%0d_pulses", v), nt, vecs[v].exp_pulses);
            check_int($sformatf("burst%0d_busy_cycles", v), nb, vecs[v].exp_busy);
        end

        // Abort during the first gap after the second pulse.
        start = 1'b1; pulse_cnt = 8'd5; gap = 8'd1;
        @(negedge clk);
        start = 1'b0;
        q_exp.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 5));
        q_exp.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4));
        q_exp.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 4));
        q_exp.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 3));
        q_exp.push_back(idle);
        q_exp.push_back(idle);
        run_q("abort_gap", 3, -1, nt, nb);
        check_int("abort_gap_pulses", nt, 2);

        // Abort and start together in IDLE: nothing is accepted.
        start = 1'b1; abort = 1'b1; pulse_cnt = 8'd3; gap = 8'd0;
        @(negedge clk);
        q_exp.push_back(idle);
        q_exp.push_back(idle);
        run_q("abort_start_idle", -1, -1, nt, nb);
        check_int("abort_start_idle_pulses", nt, 0);

        // Start while busy is dropped and the burst length stays at 4.
        start_burst(4, 1);
        run_q("start_while_busy", -1, 1, nt, nb);
        check_int("start_while_busy_pulses", nt, 4);

        // Asynchronous reset while t is high.
        start = 1'b1; pulse_cnt = 8'd3; gap = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check_obs("rst_pre", mk(1'b1, 1'b0, 1'b0, 1'b1, 3));
        #2 reset = 1'b0;
        m_q = 1'b0;
        #1 check_obs("rst_async", idle);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_obs("rst_after", idle);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
